result_tx_buffer: RTL

RESULT_TX_BUFFER -- requirements
Module: result_tx_buffer

---
 rtl/result_tx_buffer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/result_tx_buffer.sv
// Result byte buffer between the systolic array and a UART transmitter:
// a circular FIFO drained by a small handshake FSM, one byte per transmission.
module result_tx_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    res_data,
  input  logic          res_valid,
  input  logic          tx_busy,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic [AW:0]   fifo_count,
  output logic          overflow
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];

  state_t        state_q,    state_d;
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [AW:0]   count_q,    count_d;
  logic [7:0]    tx_data_q,  tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic          overflow_q, overflow_d;

  logic          push;
  logic          pop;

  assign fifo_full  = (count_q == FULL_COUNT);
  assign fifo_empty = (count_q == '0);
  assign fifo_count = count_q;
  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign overflow   = overflow_q;

  // A pop only happens in LOAD, which is entered only with data queued, so a
  // push that meets a full FIFO during LOAD still has a free slot at the edge.
  assign pop  = (state_q == LOAD);
  assign push = res_valid && (!fifo_full || pop);

  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tx_data_d  = tx_data_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (!fifo_empty && !tx_busy) state_d = LOAD;
      end
      LOAD: begin
        tx_data_d = mem[rd_ptr_q];
        rd_ptr_d  = rd_ptr_q + 1'b1;
        state_d   = START;
      end
      START: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Pointers are AW bits wide, so wrap from DEPTH-1 to 0 comes for free.
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (res_valid && !push) overflow_d = 1'b1;

    tx_start_d = (state_d == START);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; stale bytes are unreachable because
  // the pointers and count are reset, and leaving it unreset keeps it RAM-mappable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= res_data;
  end

endmodule
